aes_stream_feeder: RTL and testbench
====================================

// Module: aes_stream_feeder
// PURPOSE
//  Upstream/downstream sequencer for the AES_ENCRYPT core. Collects four 32-bit plaintext words
//  into one 128-bit block, issues a one-cycle ld to the core with block and key held stable, waits
//  for done, then returns the ciphertext as four 32-bit words. Valid/ready on both stream sides.
//  One block in flight at a time; a watchdog flags a core that never completes.
// PARAMETERS
//  TIMEOUT_CYC  32  max cycles in WAIT for aes_done before abort (must exceed core latency)
//  CNT_W        6   width of watchdog counter; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1    single clock, all logic on posedge
//  rst          in   1    reset; synchronous and active-low
//  in_valid     in   1    plaintext word valid
//  in_ready     out  1    feeder accepts word (FILL state only)
//  in_data      in   32   plaintext word; first word of block = block[127:96]
//  key          in   256  cipher key; sampled when 4th word of block accepted
//  aes_ld       out  1    to core ld; one-cycle pulse
//  aes_key      out  256  to core key; registered, stable LOAD..done
//  aes_text_in  out  128  to core text_in; registered, stable LOAD..done
//  aes_done     in   1    from core done
//  aes_text_out in   128  from core text_out; sampled when aes_done=1 in WAIT
//  out_valid    out  1    ciphertext word valid
//  out_ready    in   1    sink accepts word
//  out_data     out  32   ciphertext word; first word = ct[127:96]
//  out_last     out  1    high with 4th word of block
//  busy         out  1    state != FILL
//  timeout_err  out  1    sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=FILL, word_idx=0, aes_ld=0, out_valid=0, out_last=0,
//   timeout_err=0, busy=0, in_ready=1 after reset; aes_text_in/aes_key/out_data cleared to 0.
//  FILL: in_ready=1; on in_valid&in_ready store in_data at blk[127-32*idx -: 32], idx++.
//   On 4th transfer (idx==3): latch key into aes_key, blk into aes_text_in -> LOAD, idx=0.
//  LOAD: aes_ld=1 for exactly this one cycle; watchdog cleared -> WAIT.
//  WAIT: watchdog increments each cycle. aes_done=1 -> capture aes_text_out into ct reg -> DRAIN.
//   Watchdog == TIMEOUT_CYC-1 without done -> set timeout_err, discard block -> FILL.
//   aes_done=1 on the timeout cycle: done wins (block captured, no error).
//  DRAIN: out_valid=1, out_data=ct[127-32*idx -: 32], out_last=(idx==3). Advance idx on
//   out_valid&out_ready; data held stable while out_ready=0. After 4th transfer -> FILL, idx=0.
//  in_ready=0 in LOAD/WAIT/DRAIN; in_valid there ignored, no data lost (producer holds).
//  aes_done outside WAIT ignored. aes_ld never asserted outside LOAD (core never reloaded mid-run).
//  Latency: last in-word accept -> aes_ld 1 cycle; aes_done -> out_valid 1 cycle.
//  Throughput: one block per (4 + 1 + core latency + 1 + 4) cycles with no backpressure.
//  Reset mid-operation (any state): partial block and ciphertext discarded, all to reset values.
//  timeout_err cleared only by reset; feeder keeps operating after it is set.
// STRUCTURE
//  aes_pkg: localparams WORD_W=32, BLK_W=128, KEY_W=256, WORDS=4; state encoding
//   FILL/LOAD/WAIT/DRAIN (2-bit).
//  Sub-module aes_blk_serializer: 128-bit ct register + 2-bit index, valid/ready word output,
//   out_last; started by capture strobe, returns drained pulse. FSM, packer, watchdog in top.
// TESTING (core replaced by stub: done 14 cycles after ld, text_out = ~text_in, unless noted)
//  1 Words 00112233,44556677,8899aabb,ccddeeff back-to-back -> one aes_ld pulse with
//    aes_text_in=00112233..ccddeeff; out words ffeeddcc,bbaa9988,77665544,33221100, out_last on 4th.
//  2 Random out_ready stalls (50%) in DRAIN -> out_data stable while stalled, 4 words exactly, in_ready=0.
//  3 in_valid held high during WAIT/DRAIN -> no words consumed until FILL; next block intact.
//  4 Stub never raises done -> timeout_err=1 after TIMEOUT_CYC cycles in WAIT, state FILL, no out_valid.
//  5 Stub done on exact timeout cycle -> ct delivered, timeout_err stays 0.
//  6 rst=0 after 2 words, and again mid-DRAIN -> outputs at reset values next cycle; fresh block
//    then encrypts correctly; integration run with real AES_ENCRYPT vs team golden model.

Source files
------------

// File: rtl/aes_stream_feeder_pkg.sv
// Shared widths, state encoding and bus types for the AES stream feeder.
package aes_stream_feeder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned IDX_W  = 2;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BLK_W-1:0]  blk_t;
    typedef logic [KEY_W-1:0]  key_t;

endpackage

// File: rtl/aes_stream_feeder_if.sv
// Plaintext-in and ciphertext-out word streams of the feeder (valid/ready both sides).
interface aes_stream_feeder_if;
    import aes_stream_feeder_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    logic  out_last;

    // master: producer/sink environment; slave: the feeder
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/aes_blk_serializer.sv
// Holds one ciphertext block and emits it as four valid/ready words, MSW first.
module aes_blk_serializer
    import aes_stream_feeder_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  capture,
    input  blk_t  ct,
    output logic  out_valid,
    input  logic  out_ready,
    output word_t out_data,
    output logic  out_last,
    output logic  drained_c
);

    logic [BLK_W-WORD_W-1:0] rest;
    logic [IDX_W-1:0]        idx;

    assign drained_c = out_valid & out_ready & out_last;

    // Remaining words shift up into out_data on each accepted transfer
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            rest      <= '0;
            idx       <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= ct[BLK_W-1 -: WORD_W];
            rest      <= ct[BLK_W-WORD_W-1:0];
            out_last  <= 1'b0;
            idx       <= '0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                idx       <= '0;
            end else begin
                out_data  <= rest[BLK_W-WORD_W-1 -: WORD_W];
                rest      <= {rest[BLK_W-2*WORD_W-1:0], WORD_W'(0)};
                idx       <= idx + IDX_W'(1);
                out_last  <= (idx == IDX_W'(WORDS-2));
            end
        end
    end

endmodule

// File: rtl/aes_stream_feeder.sv
// Sequencer around the AES_ENCRYPT core: packs four words, loads the core, waits
// (with watchdog) for done, then streams the ciphertext back out.
module aes_stream_feeder
    import aes_stream_feeder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic                clk,
    input  logic                rst,
    aes_stream_feeder_if.slave  io,
    input  key_t                key,
    output logic                aes_ld,
    output key_t                aes_key,
    output blk_t                aes_text_in,
    input  logic                aes_done,
    input  blk_t                aes_text_out,
    output logic                busy,
    output logic                timeout_err
);

    logic [1:0]              state;
    logic [1:0]              next_state;
    logic [IDX_W-1:0]        fill_idx;
    logic [BLK_W-WORD_W-1:0] acc;
    logic [CNT_W-1:0]        wdog;
    logic                    accept_c;
    logic                    load_c;
    logic                    capture_c;
    logic                    timeout_c;
    logic                    drained_c;

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_FILL;
        else      state <= next_state;
    end

    // Next state and per-cycle strobes; done beats the watchdog on the same cycle
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        load_c     = 1'b0;
        capture_c  = 1'b0;
        timeout_c  = 1'b0;
        case (state)
            ST_FILL: begin
                if (io.in_valid && io.in_ready) begin
                    accept_c = 1'b1;
                    if (fill_idx == IDX_W'(WORDS-1)) begin
                        load_c     = 1'b1;
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: next_state = ST_WAIT;
            ST_WAIT: begin
                if (aes_done) begin
                    capture_c  = 1'b1;
                    next_state = ST_DRAIN;
                end else if (wdog == CNT_W'(TIMEOUT_CYC-1)) begin
                    timeout_c  = 1'b1;
                    next_state = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (drained_c) next_state = ST_FILL;
            end
            default: next_state = ST_FILL;
        endcase
    end

    // Registered outputs follow next_state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            aes_ld      <= 1'b0;
            busy        <= 1'b0;
            io.in_ready <= 1'b1;
            fill_idx    <= '0;
            acc         <= '0;
            aes_key     <= '0;
            aes_text_in <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            aes_ld      <= (next_state == ST_LOAD);
            busy        <= (next_state != ST_FILL);
            io.in_ready <= (next_state == ST_FILL);
            if (accept_c) begin
                fill_idx <= fill_idx + IDX_W'(1);
                acc      <= {acc[BLK_W-2*WORD_W-1:0], io.in_data};
            end
            if (load_c) begin
                aes_key     <= key;
                aes_text_in <= {acc, io.in_data};
            end
            if (state == ST_WAIT) wdog <= wdog + CNT_W'(1);
            else                  wdog <= '0;
            if (timeout_c) timeout_err <= 1'b1;
        end
    end

    aes_blk_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture_c),
        .ct        (aes_text_out),
        .out_valid (io.out_valid),
        .out_ready (io.out_ready),
        .out_data  (io.out_data),
        .out_last  (io.out_last),
        .drained_c (drained_c)
    );

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Bench for aes_stream_feeder with a stub core (text_out = ~text_in after a set delay).
module tb_aes_stream_feeder;
    import aes_stream_feeder_pkg::*;

    localparam int unsigned TIMEOUT_CYC = 32;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    key_t  key = '0;
    logic  aes_ld;
    key_t  aes_key;
    blk_t  aes_text_in;
    logic  aes_done;
    blk_t  aes_text_out;
    logic  busy;
    logic  timeout_err;

    always #5 clk = ~clk;

    aes_stream_feeder_if io();

    aes_stream_feeder #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .io           (io),
        .key          (key),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // Stub core: done one cycle, stub_delay clocks after it samples ld
    int unsigned stub_delay = 14;
    logic        stub_en    = 1'b1;
    int unsigned stub_cnt;
    blk_t        stub_ct;
    always @(posedge clk) begin
        if (!rst) stub_cnt <= 0;
        else if (aes_ld) begin
            stub_cnt <= stub_delay;
            stub_ct  <= ~aes_text_in;
        end else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    end
    assign aes_done     = stub_en && (stub_cnt == 1);
    assign aes_text_out = stub_ct;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Sink: always ready, or a coin flip per cycle in stall mode
    logic stall_mode = 1'b0;
    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            io.out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Transaction model: accepted words form blocks; each load must carry the next
    // block; a core that answers within the timeout yields ~block as four words.
    word_t in_acc[$];
    blk_t  exp_blk[$];
    key_t  exp_key[$];
    word_t exp_words[$];
    blk_t  got_ld[$];
    word_t got_words[$];
    logic  got_last[$];
    int    beat = 0;
    logic  prev_stall = 1'b0;
    word_t prev_data = '0;
    logic  prev_ld = 1'b0;

    always @(negedge clk) begin : model
        blk_t  b;
        key_t  k;
        word_t w;
        if (!rst) begin
            in_acc.delete();
            exp_blk.delete();
            exp_key.delete();
            exp_words.delete();
            beat       = 0;
            prev_stall = 1'b0;
            prev_ld    = 1'b0;
        end else begin
            chk("in_ready_vs_busy", io.in_ready, !busy);
            if (aes_ld) begin
                chk("ld_single_cycle", prev_ld, 1'b0);
                if (exp_blk.size() == 0) fail("ld_unexpected");
                else begin
                    b = exp_blk.pop_front();
                    k = exp_key.pop_front();
                    chk("ld_text", aes_text_in, b);
                    chk("ld_key", aes_key, k);
                    got_ld.push_back(aes_text_in);
                    if (stub_en && stub_delay <= TIMEOUT_CYC)
                        for (int i = 0; i < 4; i++)
                            exp_words.push_back(~b[BLK_W-1-WORD_W*i -: WORD_W]);
                end
            end
            if (prev_stall) begin
                chk("stall_hold_valid", io.out_valid, 1'b1);
                chk("stall_hold_data", io.out_data, prev_data);
            end
            if (io.out_valid) begin
                if (exp_words.size() == 0) fail("unexpected_out_word");
                else begin
                    chk("out_data", io.out_data, exp_words[0]);
                    chk("out_last", io.out_last, beat == 3);
                    chk("out_busy", busy, 1'b1);
                    if (io.out_ready) begin
                        w = exp_words.pop_front();
                        got_words.push_back(io.out_data);
                        got_last.push_back(io.out_last);
                        beat = (beat + 1) % 4;
                    end
                end
            end
            if (io.in_valid && io.in_ready) begin
                in_acc.push_back(io.in_data);
                if (in_acc.size() == 4) begin
                    exp_blk.push_back({in_acc[0], in_acc[1], in_acc[2], in_acc[3]});
                    exp_key.push_back(key);
                    in_acc.delete();
                end
            end
            prev_stall = io.out_valid && !io.out_ready;
            prev_data  = io.out_data;
            prev_ld    = aes_ld;
        end
    end

    task automatic put_word(input word_t w);
        int n = 0;
        io.in_valid = 1'b1;
        io.in_data  = w;
        @(negedge clk);
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            fail("in_accept_timeout");
            io.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic send_block(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
        put_word(w0);
        put_word(w1);
        put_word(w2);
        put_word(w3);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_words.size() != 0 || exp_blk.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_words.size() != 0 || exp_blk.size() != 0) fail("idle_timeout");
        sync();
    endtask

    task automatic clear_logs();
        got_ld.delete();
        got_words.delete();
        got_last.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_aes_ld"}, aes_ld, 1'b0);
        chk({tag, "_out_valid"}, io.out_valid, 1'b0);
        chk({tag, "_out_last"}, io.out_last, 1'b0);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_in_ready"}, io.in_ready, 1'b1);
        chk({tag, "_text_in"}, aes_text_in, '0);
        chk({tag, "_key"}, aes_key, '0);
        chk({tag, "_out_data"}, io.out_data, '0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset(tag);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        io.in_valid = 1'b0;
        io.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b1;

        // 1: known vector, latencies and literal ciphertext words
        clear_logs();
        key = {8{32'h0f1e2d3c}};
        send_block(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        chk("ld_latency", aes_ld, 1'b1);
        repeat (15) @(negedge clk);
        chk("out_valid_before_done", io.out_valid, 1'b0);
        @(negedge clk);
        chk("out_valid_after_done", io.out_valid, 1'b1);
        wait_idle();
        chk("t1_ld_count", got_ld.size(), 1);
        chk("t1_text_in", got_ld[0], 128'h00112233_44556677_8899aabb_ccddeeff);
        chk("t1_word_count", got_words.size(), 4);
        chk("t1_w0", got_words[0], 32'hffeeddcc);
        chk("t1_w1", got_words[1], 32'hbbaa9988);
        chk("t1_w2", got_words[2], 32'h77665544);
        chk("t1_w3", got_words[3], 32'h33221100);
        chk("t1_last0", got_last[0], 1'b0);
        chk("t1_last3", got_last[3], 1'b1);

        // 2: random sink backpressure
        clear_logs();
        stall_mode = 1'b1;
        key = {4{64'h0123456789abcdef}};
        send_block(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);
        wait_idle();
        stall_mode = 1'b0;
        chk("t2_word_count", got_words.size(), 4);
        chk("t2_w0", got_words[0], 32'hfedcba98);
        chk("t2_w3", got_words[3], 32'h89abcdef);

        // 3: next block presented while busy must wait for FILL
        clear_logs();
        key = {8{32'ha5a5_5a5a}};
        send_block(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        send_block(32'hcafef00d, 32'h12345678, 32'h9abcdef0, 32'h0badc0de);
        wait_idle();
        chk("t3_ld_count", got_ld.size(), 2);
        chk("t3_blk2", got_ld[1], 128'hcafef00d_12345678_9abcdef0_0badc0de);
        chk("t3_word_count", got_words.size(), 8);
        chk("t3_blk2_w0", got_words[4], 32'h35010ff2);

        // 5: done arrives on the final watchdog cycle
        clear_logs();
        stub_delay = TIMEOUT_CYC;
        send_block(32'hdeadbeef, 32'h00000000, 32'hffffffff, 32'h5555aaaa);
        wait_idle();
        stub_delay = 14;
        chk("t5_timeout_err", timeout_err, 1'b0);
        chk("t5_word_count", got_words.size(), 4);
        chk("t5_w0", got_words[0], 32'h21524110);

        // 4: core never answers
        clear_logs();
        stub_en = 1'b0;
        send_block(32'h0000000a, 32'h0000000b, 32'h0000000c, 32'h0000000d);
        @(negedge clk);
        chk("t4_ld", aes_ld, 1'b1);
        repeat (TIMEOUT_CYC) @(negedge clk);
        chk("t4_err_not_yet", timeout_err, 1'b0);
        chk("t4_busy_in_wait", busy, 1'b1);
        @(negedge clk);
        chk("t4_err_set", timeout_err, 1'b1);
        chk("t4_back_to_fill", busy, 1'b0);
        chk("t4_in_ready", io.in_ready, 1'b1);
        sync();
        stub_en = 1'b1;
        send_block(32'h10203040, 32'h50607080, 32'h90a0b0c0, 32'hd0e0f000);
        wait_idle();
        chk("t4_err_sticky", timeout_err, 1'b1);
        chk("t4_word_count", got_words.size(), 4);

        // 6: reset after two words, then mid-drain
        clear_logs();
        put_word(32'hbad00001);
        put_word(32'hbad00002);
        do_reset("rst_fill");
        key = {8{32'h13579bdf}};
        send_block(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f);
        wait_idle();
        chk("t6a_text_in", got_ld[0], 128'h00010203_04050607_08090a0b_0c0d0e0f);
        chk("t6a_word_count", got_words.size(), 4);
        chk("t6a_w3", got_words[3], 32'hf3f2f1f0);

        clear_logs();
        send_block(32'haaaa0000, 32'hbbbb1111, 32'hcccc2222, 32'hdddd3333);
        begin
            int n = 0;
            @(negedge clk);
            while (!io.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!io.out_valid) fail("t6b_no_drain");
        end
        do_reset("rst_drain");
        clear_logs();
        send_block(32'h0f0f0f0f, 32'hf0f0f0f0, 32'h00ff00ff, 32'hff00ff00);
        wait_idle();
        chk("t6b_word_count", got_words.size(), 4);
        chk("t6b_w0", got_words[0], 32'hf0f0f0f0);
        chk("t6b_w2", got_words[2], 32'hff00ff00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
